pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirect squash, bus freeze.
// Optional performance counters are built when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int BUS_TIMEOUT  = 15,
    parameter int CNT_W        = 16
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_re,
    input  logic             id_rs2_re,
    input  logic [4:0]       ex_wr,
    input  logic             ex_rf_we,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic             mem_bus_req,
    input  logic             bus_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_bubble,
`ifdef PIPE_HAZARD_PERF_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles,
`endif
    output logic             bus_timeout
);

    localparam int WC_W = $clog2(BUS_TIMEOUT + 1);
    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        BUS_WAIT = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WC_W-1:0]   wait_cnt_q;
    logic [WC_W-1:0]   wait_cnt_d;
    logic [FC_W-1:0]   flush_cnt_q;
    logic [FC_W-1:0]   flush_cnt_d;
    logic              timeout_set;

    logic              bus_wait;
    logic              load_use;
    logic              freeze;
    logic              squash_if;
    logic              squash_id;
    logic              lu_stall;

    assign bus_wait = mem_bus_req & ~bus_ready;

    // x0 is hardwired, so a load targeting it never creates a dependency
    assign load_use = ex_is_load & ex_rf_we & (ex_wr != 5'd0) &
                      ((id_rs1_re & (id_rs1 == ex_wr)) |
                       (id_rs2_re & (id_rs2 == ex_wr)));

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            flush_cnt_q <= '0;
            bus_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            if (timeout_set) begin
                bus_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        flush_cnt_d = flush_cnt_q;
        timeout_set = 1'b0;
        freeze      = 1'b0;
        squash_if   = 1'b0;
        squash_id   = 1'b0;
        lu_stall    = 1'b0;
        case (state_q)
            RUN: begin
                if (bus_wait) begin
                    freeze     = 1'b1;
                    wait_cnt_d = WC_W'(1);
                    state_d    = BUS_WAIT;
                end else if (ex_redirect) begin
                    // a squashed ID instruction cannot need a load-use stall
                    squash_if = 1'b1;
                    squash_id = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
                        state_d     = FLUSH;
                    end
                end else if (load_use) begin
                    lu_stall = 1'b1;
                end
            end
            FLUSH: begin
                if (bus_wait) begin
                    freeze     = 1'b1;
                    wait_cnt_d = WC_W'(1);
                    state_d    = BUS_WAIT;
                end else if (ex_redirect) begin
                    squash_if   = 1'b1;
                    squash_id   = 1'b1;
                    flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
                end else begin
                    squash_if = 1'b1;
                    if (flush_cnt_q <= FC_W'(1)) begin
                        state_d = RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - FC_W'(1);
                    end
                end
            end
            BUS_WAIT: begin
                // the whole pipe is frozen, so redirects wait until RUN
                if (bus_ready) begin
                    state_d = RUN;
                end else if (wait_cnt_q >= WC_W'(BUS_TIMEOUT)) begin
                    timeout_set = 1'b1;
                    state_d     = RUN;
                end else begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign pc_stall      = ~cpu_rst & (freeze | lu_stall);
    assign if_id_stall   = ~cpu_rst & (freeze | lu_stall);
    assign if_id_flush   = ~cpu_rst & squash_if;
    assign id_ex_stall   = ~cpu_rst & freeze;
    assign id_ex_flush   = ~cpu_rst & (squash_id | lu_stall);
    assign ex_mem_stall  = ~cpu_rst & freeze;
    assign mem_wb_bubble = ~cpu_rst & freeze;

`ifdef PIPE_HAZARD_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (pc_stall) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
            if (if_id_flush) begin
                flush_cycles <= sat_inc(flush_cycles);
            end
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int FLUSH_CYCLES = 2;
    localparam int BUS_TIMEOUT  = 15;
    localparam int CNT_W        = 16;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    // output vector: pc_stall, if_id_stall, if_id_flush, id_ex_stall,
    // id_ex_flush, ex_mem_stall, mem_wb_bubble, bus_timeout
    localparam logic [7:0] FRZ = 8'b1101_0110;
    localparam logic [7:0] FB  = 8'b0010_1000;
    localparam logic [7:0] FI  = 8'b0010_0000;
    localparam logic [7:0] LU  = 8'b1100_1000;
    localparam logic [7:0] Z   = 8'b0000_0000;

    logic       cpu_clk = 1'b0;
    logic       cpu_rst;
    logic [4:0] id_rs1, id_rs2, ex_wr;
    logic       id_rs1_re, id_rs2_re, ex_rf_we, ex_is_load, ex_redirect;
    logic       mem_bus_req, bus_ready;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic       ex_mem_stall, mem_wb_bubble, bus_timeout;
`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cycles, flush_cycles;
`endif

    logic [7:0] obs_v;
    assign obs_v = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                    id_ex_flush, ex_mem_stall, mem_wb_bubble, bus_timeout};

    int compared   = 0;
    int mismatched = 0;

    // behavioural model state
    int         m_wait_len;
    int         m_flush_left;
    bit         m_timeout;
    int         m_stall_cnt;
    int         m_flush_cnt;
    logic [7:0] exp_v;
    int         exp_stall_cnt;
    int         exp_flush_cnt;

    always #5 cpu_clk = ~cpu_clk;

    pipe_hazard_ctrl #(
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .BUS_TIMEOUT (BUS_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .cpu_clk      (cpu_clk),
        .cpu_rst      (cpu_rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_re    (id_rs1_re),
        .id_rs2_re    (id_rs2_re),
        .ex_wr        (ex_wr),
        .ex_rf_we     (ex_rf_we),
        .ex_is_load   (ex_is_load),
        .ex_redirect  (ex_redirect),
        .mem_bus_req  (mem_bus_req),
        .bus_ready    (bus_ready),
        .pc_stall     (pc_stall),
        .if_id_stall  (if_id_stall),
        .if_id_flush  (if_id_flush),
        .id_ex_stall  (id_ex_stall),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_stall (ex_mem_stall),
        .mem_wb_bubble(mem_wb_bubble),
`ifdef PIPE_HAZARD_PERF_EN
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles),
`endif
        .bus_timeout  (bus_timeout)
    );

    function automatic logic [21:0] stim(input int rs1, input int rs2, input bit re1, input bit re2,
                                         input int wr, input bit we, input bit ld, input bit redir,
                                         input bit req, input bit rdy);
        return {5'(rs1), 5'(rs2), re1, re2, 5'(wr), we, ld, redir, req, rdy};
    endfunction

    task automatic apply(input logic [21:0] s);
        {id_rs1, id_rs2, id_rs1_re, id_rs2_re, ex_wr, ex_rf_we, ex_is_load,
         ex_redirect, mem_bus_req, bus_ready} = s;
    endtask

    // Expected outputs for the current cycle from the current inputs, then advance the model.
    task automatic model_eval();
        bit         hz;
        bit         set_to;
        logic [7:0] v;
        if (cpu_rst) begin
            m_wait_len = 0; m_flush_left = 0; m_timeout = 0;
            m_stall_cnt = 0; m_flush_cnt = 0;
            exp_v = '0; exp_stall_cnt = 0; exp_flush_cnt = 0;
            return;
        end
        exp_stall_cnt = m_stall_cnt;
        exp_flush_cnt = m_flush_cnt;
        hz = ex_is_load && ex_rf_we && (ex_wr != 0) &&
             ((id_rs1_re && id_rs1 == ex_wr) || (id_rs2_re && id_rs2 == ex_wr));
        v = Z;
        set_to = 0;
        if (m_wait_len > 0) begin
            if (bus_ready) m_wait_len = 0;
            else if (m_wait_len >= BUS_TIMEOUT) begin m_wait_len = 0; set_to = 1; end
            else begin v = FRZ; m_wait_len++; end
        end else if (mem_bus_req && !bus_ready) begin
            v = FRZ; m_wait_len = 1; m_flush_left = 0;
        end else if (ex_redirect) begin
            v = FB; m_flush_left = FLUSH_CYCLES - 1;
        end else if (m_flush_left > 0) begin
            v = FI; m_flush_left--;
        end else if (hz) begin
            v = LU;
        end
        v[0] = m_timeout;
        if (set_to) m_timeout = 1;
        if (v[7] && m_stall_cnt < CNT_MAX) m_stall_cnt++;
        if (v[5] && m_flush_cnt < CNT_MAX) m_flush_cnt++;
        exp_v = v;
    endtask

    task automatic test_reset();
        cpu_rst = 1'b1;
        apply(stim(5, 5, 1, 1, 5, 1, 1, 1, 1, 0));
        model_eval();
        @(negedge cpu_clk);
        compared++;
        if (obs_v !== Z) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b want %b", obs_v, Z);
        end
`ifdef PIPE_HAZARD_PERF_EN
        compared++;
        if (stall_cycles !== '0 || flush_cycles !== '0) begin
            mismatched++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cycles, flush_cycles);
        end
`endif
        @(posedge cpu_clk); #1;
        cpu_rst = 1'b0;
        apply('0);
        model_eval();
        @(negedge cpu_clk);
        compared++;
        if (obs_v !== Z) begin
            mismatched++;
            $display("FAIL reset_release: got %b want %b", obs_v, Z);
        end
        @(posedge cpu_clk); #1;
    endtask

    task automatic test_load_use();
        logic [21:0] s [5];
        logic [7:0]  e [5];
        s[0] = stim(5, 7, 1, 1, 5, 1, 1, 0, 0, 0); e[0] = LU;
        s[1] = stim(5, 7, 1, 1, 3, 0, 0, 0, 1, 1); e[1] = Z;
        s[2] = stim(4, 9, 1, 1, 9, 1, 1, 0, 0, 0); e[2] = LU;
        s[3] = stim(5, 9, 0, 1, 5, 1, 1, 0, 0, 0); e[3] = Z;
        s[4] = stim(5, 5, 1, 1, 5, 1, 0, 0, 0, 0); e[4] = Z;
        for (int i = 0; i < 5; i++) begin
            apply(s[i]);
            model_eval();
            @(negedge cpu_clk);
            compared++;
            if (obs_v !== e[i]) begin
                mismatched++;
                $display("FAIL load_use[%0d]: got %b want %b", i, obs_v, e[i]);
            end
            @(posedge cpu_clk); #1;
        end
    endtask

    task automatic test_redirect();
        logic [21:0] s [11];
        logic [7:0]  e [11];
        s[0]  = stim(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); e[0]  = FB;
        s[1]  = '0;                                 e[1]  = FI;
        s[2]  = '0;                                 e[2]  = Z;
        s[3]  = stim(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); e[3]  = FB;
        s[4]  = stim(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); e[4]  = FB;
        s[5]  = '0;                                 e[5]  = FI;
        s[6]  = '0;                                 e[6]  = Z;
        s[7]  = stim(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); e[7]  = FB;
        s[8]  = stim(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[8]  = FRZ;
        s[9]  = stim(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); e[9]  = Z;
        s[10] = '0;                                 e[10] = Z;
        for (int i = 0; i < 11; i++) begin
            apply(s[i]);
            model_eval();
            @(negedge cpu_clk);
            compared++;
            if (obs_v !== e[i]) begin
                mismatched++;
                $display("FAIL redirect[%0d]: got %b want %b", i, obs_v, e[i]);
            end
            @(posedge cpu_clk); #1;
        end
    endtask

    task automatic test_bus_wait();
        logic [21:0] s [11];
        logic [7:0]  e [11];
        s[0]  = stim(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[0]  = FRZ;
        s[1]  = stim(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[1]  = FRZ;
        s[2]  = stim(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[2]  = FRZ;
        s[3]  = stim(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); e[3]  = Z;
        s[4]  = '0;                                 e[4]  = Z;
        s[5]  = stim(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[5]  = FRZ;
        s[6]  = stim(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); e[6]  = FRZ;
        s[7]  = stim(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); e[7]  = Z;
        s[8]  = stim(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); e[8]  = FB;
        s[9]  = '0;                                 e[9]  = FI;
        s[10] = '0;                                 e[10] = Z;
        for (int i = 0; i < 11; i++) begin
            apply(s[i]);
            model_eval();
            @(negedge cpu_clk);
            compared++;
            if (obs_v !== e[i]) begin
                mismatched++;
                $display("FAIL bus_wait[%0d]: got %b want %b", i, obs_v, e[i]);
            end
            @(posedge cpu_clk); #1;
        end
    endtask

    task automatic test_lu_redirect_x0();
        logic [21:0] s [7];
        logic [7:0]  e [7];
        s[0] = stim(5, 0, 1, 0, 5, 1, 1, 1, 0, 0); e[0] = FB;
        s[1] = '0;                                 e[1] = FI;
        s[2] = '0;                                 e[2] = Z;
        s[3] = stim(0, 0, 1, 1, 0, 1, 1, 0, 0, 0); e[3] = Z;
        s[4] = stim(6, 0, 1, 0, 6, 1, 1, 0, 1, 0); e[4] = FRZ;
        s[5] = stim(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); e[5] = Z;
        s[6] = stim(6, 6, 1, 1, 6, 0, 1, 0, 0, 0); e[6] = Z;
        for (int i = 0; i < 7; i++) begin
            apply(s[i]);
            model_eval();
            @(negedge cpu_clk);
            compared++;
            if (obs_v !== e[i]) begin
                mismatched++;
                $display("FAIL lu_redirect_x0[%0d]: got %b want %b", i, obs_v, e[i]);
            end
            @(posedge cpu_clk); #1;
        end
    endtask

    task automatic test_timeout();
        logic [7:0] e;
        for (int i = 0; i < BUS_TIMEOUT + 4; i++) begin
            if (i <= BUS_TIMEOUT) begin
                apply(stim(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
                e = (i < BUS_TIMEOUT) ? FRZ : Z;
            end else begin
                apply('0);
                e = 8'b0000_0001;
            end
            model_eval();
            @(negedge cpu_clk);
            compared++;
            if (obs_v !== e) begin
                mismatched++;
                $display("FAIL timeout[%0d]: got %b want %b", i, obs_v, e);
            end
            @(posedge cpu_clk); #1;
        end
    endtask

    task automatic test_reset_mid_wait();
        for (int i = 0; i < 2; i++) begin
            apply(stim(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
            model_eval();
            @(negedge cpu_clk);
            compared++;
            if (obs_v !== (FRZ | 8'b1)) begin
                mismatched++;
                $display("FAIL mid_wait_pre[%0d]: got %b want %b", i, obs_v, FRZ | 8'b1);
            end
            @(posedge cpu_clk); #1;
        end
        apply(stim(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        #1;
        cpu_rst = 1'b1;
        #1;
        compared++;
        if (obs_v !== Z) begin
            mismatched++;
            $display("FAIL mid_wait_async: got %b want %b", obs_v, Z);
        end
`ifdef PIPE_HAZARD_PERF_EN
        compared++;
        if (stall_cycles !== '0 || flush_cycles !== '0) begin
            mismatched++;
            $display("FAIL mid_wait_counters: got %0d/%0d want 0/0", stall_cycles, flush_cycles);
        end
`endif
        model_eval();
        @(posedge cpu_clk); #1;
        cpu_rst = 1'b0;
        apply(stim(3, 0, 1, 0, 3, 1, 1, 0, 0, 0));
        model_eval();
        @(negedge cpu_clk);
        compared++;
        if (obs_v !== LU) begin
            mismatched++;
            $display("FAIL mid_wait_run: got %b want %b", obs_v, LU);
        end
        @(posedge cpu_clk); #1;
        apply('0);
        model_eval();
        @(negedge cpu_clk);
        compared++;
        if (obs_v !== Z) begin
            mismatched++;
            $display("FAIL mid_wait_idle: got %b want %b", obs_v, Z);
        end
`ifdef PIPE_HAZARD_PERF_EN
        compared++;
        if (stall_cycles !== CNT_W'(1) || flush_cycles !== '0) begin
            mismatched++;
            $display("FAIL mid_wait_count_after: got %0d/%0d want 1/0", stall_cycles, flush_cycles);
        end
`endif
        @(posedge cpu_clk); #1;
    endtask

    task automatic test_random();
        logic [21:0] s;
        bit          rdy;
        for (int i = 0; i < 800; i++) begin
            cpu_rst = ($urandom_range(0, 149) == 0);
            rdy = (i < 400) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) == 0);
            s = stim(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 0),
                     int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 1) == 0), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 3) == 0), rdy);
            apply(s);
            model_eval();
            @(negedge cpu_clk);
            compared++;
            if (obs_v !== exp_v) begin
                mismatched++;
                $display("FAIL random[%0d]: got %b want %b", i, obs_v, exp_v);
            end
`ifdef PIPE_HAZARD_PERF_EN
            compared++;
            if (stall_cycles !== CNT_W'(exp_stall_cnt) || flush_cycles !== CNT_W'(exp_flush_cnt)) begin
                mismatched++;
                $display("FAIL random_counters[%0d]: got %0d/%0d want %0d/%0d",
                         i, stall_cycles, flush_cycles, exp_stall_cnt, exp_flush_cnt);
            end
`endif
            @(posedge cpu_clk); #1;
        end
        cpu_rst = 1'b0;
    endtask

    initial begin
        cpu_rst = 1'b1;
        apply('0);
        test_reset();
        test_load_use();
        test_redirect();
        test_bus_wait();
        test_lu_redirect_x0();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
